regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, is the register width in bits.
REQ-002 Parameter ADDR_W, default 5, is the register address width; derived depth NREG = 2**ADDR_W.
REQ-003 Parameter NRD, default 2, is the number of independent read ports; the number of write ports is fixed at 2.
REQ-004 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, is the synchronous, active-high reset.
REQ-006 Port clr, input, 1, is a one-cycle pulse requesting a full register clear.
REQ-007 Port rs, input, NRD*ADDR_W, carries the packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
REQ-008 Port rv, output, NRD*DATA_W, carries the packed read data; port i uses bits [i*DATA_W +: DATA_W].
REQ-009 Port we, input, 2, carries the per-write-port enables.
REQ-010 Port rd, input, 2*ADDR_W, carries the packed write addresses.
REQ-011 Port wdata, input, 2*DATA_W, carries the packed write data.
REQ-012 Port dbg_addr, input, ADDR_W, is the debug read address.
REQ-013 Port dbg_data, output, DATA_W, is the debug read data.
REQ-014 Port busy, output, 1, is high while a clear sequence runs.

Function
REQ-015 Reads are combinational (zero latency): rv[i] = REG[rs[i]]; dbg_data = REG[dbg_addr].
REQ-016 Address 0 is hardwired to zero: no storage, writes to it are dropped, and reads of it return 0 on every port.
REQ-017 A write takes effect at the rising edge when we[k]=1, rd[k]!=0 and busy=0; the new value is visible to reads from the next cycle.
REQ-018 If both write ports target the same nonzero address in one cycle, port 1 wins and port 0's data is discarded.
REQ-019 The clear FSM has states IDLE and CLEAR; an address counter clr_ptr has width ADDR_W.
REQ-020 IDLE -> CLEAR on clr=1, with clr_ptr loaded to 1; busy=1 in CLEAR.
REQ-021 In CLEAR, REG[clr_ptr] <= 0 and clr_ptr increments each cycle; the transition CLEAR -> IDLE occurs in the cycle clr_ptr = NREG-1, so a clear takes NREG-1 cycles.
REQ-022 In CLEAR, all writes are ignored, rv and dbg_data read 0, and clr is ignored (no restart).
REQ-023 The clr_ptr counter does not wrap: exit occurs at NREG-1 before any increment past it.

Reset
REQ-024 rst=1 forces state CLEAR and clr_ptr=1, overriding clr and writes in that cycle.
REQ-025 Output values after reset: busy=1, rv=0, dbg_data=0; busy falls NREG-1 cycles after rst deasserts.
REQ-026 rst asserted mid-CLEAR restarts the sequence from clr_ptr=1.

Configuration
REQ-027 When macro REGFILE_MP_BYPASS_EN is defined, a read (rv or dbg) whose address matches an accepted write in the same cycle returns that write's data; port 1 takes priority over port 0, and address 0 is still read as 0.
REQ-028 When REGFILE_MP_BYPASS_EN is undefined, same-cycle reads return the pre-write stored value.

Structure
REQ-029 Package regfile_mp_pkg holds the FSM state typedef (IDLE, CLEAR) and the default DATA_W/ADDR_W constants.
REQ-030 The clear FSM and clr_ptr live in sub-module regfile_mp_clr, with outputs busy, clr_we and clr_addr.
REQ-031 The storage array and write/bypass muxing stay in regfile_mp.

Verification
REQ-032 Scenario rst for 1 cycle then release: busy=1 for exactly 31 cycles with defaults, then 0; every register reads 0.
REQ-033 Scenario write 0xDEADBEEF to x5 on port 0, then read rs[0]=5 next cycle: rv[0]=0xDEADBEEF; a write to x0 of 0x1 leaves x0 reading 0.
REQ-034 Scenario both ports write x7 with 0x11 (port 0) and 0x22 (port 1) in the same cycle: x7=0x22 afterwards.
REQ-035 Scenario, with REGFILE_MP_BYPASS_EN, write x3=0xA5A5A5A5 while rs[1]=3: rv[1]=0xA5A5A5A5 in the same cycle; without the macro, rv[1] equals the old value.
REQ-036 Scenario pulse clr with x31=0x1234: busy rises the next cycle, writes are dropped during CLEAR, and x31 reads 0 after busy falls.
REQ-037 Scenario assert rst at clr_ptr=10 during CLEAR: the sequence restarts and busy stays high for 31 more cycles after rst drops.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_mp_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/regfile_mp_clr.sv
// Clear sequencer: walks clr_ptr from 1 to NREG-1, zeroing one register per
// cycle. busy is high for the whole walk; reset restarts the walk.
module regfile_mp_clr
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // Last address is all-ones (NREG-1); exit there so the pointer never wraps.
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);

  clr_state_t        state;
  logic [ADDR_W-1:0] clr_ptr;

  // FSM and pointer; reset forces a fresh clear from address 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= FIRST;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state   <= CLEAR;
            clr_ptr <= FIRST;
          end
        end
        CLEAR: begin
          if (clr_ptr == LAST) state <= IDLE;
          else                 clr_ptr <= clr_ptr + FIRST;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports plus a debug port,
// two write ports (port 1 wins on collision), x0 hardwired to zero, and a
// sequenced full clear. Optional same-cycle write-to-read forwarding is
// enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [NRD*ADDR_W-1:0] rs,
  output logic [NRD*DATA_W-1:0] rv,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   rd,
  input  logic [2*DATA_W-1:0]   wdata,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic                  busy
);

  localparam int NREG = 2 ** ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  regfile_mp_clr #(.ADDR_W(ADDR_W)) u_clr (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  // x0 has no storage.
  logic [DATA_W-1:0] mem [1:NREG-1];

  logic [ADDR_W-1:0] waddr [2];
  logic [DATA_W-1:0] wd    [2];
  logic [1:0]        wen;
  logic              blank;

  // Reads and writes are both suppressed while clearing or in reset.
  assign blank = busy | rst;

  for (genvar k = 0; k < 2; k++) begin : g_wr
    assign waddr[k] = rd[k*ADDR_W +: ADDR_W];
    assign wd[k]    = wdata[k*DATA_W +: DATA_W];
    assign wen[k]   = we[k] & (waddr[k] != '0) & ~blank;
  end

  // Storage update: clear walk has priority; port 1 is written last so it wins.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wen[0]) mem[waddr[0]] <= wd[0];
      if (wen[1]) mem[waddr[1]] <= wd[1];
    end
  end

  // Read ports 0..NRD-1 plus the debug port at index NRD share one read path.
  logic [ADDR_W-1:0] raddr [NRD+1];
  logic [DATA_W-1:0] rdata [NRD+1];

  assign raddr[NRD] = dbg_addr;
  assign dbg_data   = rdata[NRD];

  for (genvar i = 0; i <= NRD; i++) begin : g_rd
    if (i < NRD) begin : g_port
      assign raddr[i]              = rs[i*ADDR_W +: ADDR_W];
      assign rv[i*DATA_W +: DATA_W] = rdata[i];
    end

    // Combinational read with x0 and clear/reset masking.
    always_comb begin
      rdata[i] = '0;
      if (!blank && raddr[i] != '0) begin
        rdata[i] = mem[raddr[i]];
`ifdef REGFILE_MP_BYPASS_EN
        if (wen[0] && waddr[0] == raddr[i]) rdata[i] = wd[0];
        if (wen[1] && waddr[1] == raddr[i]) rdata[i] = wd[1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a driver applies directed and random
// cycles, pushing the expected outputs for each cycle into a queue; a monitor
// on the falling edge pops and compares.
module tb_regfile_mp;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NREG = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clr = 1'b0;
  logic [NRD*AW-1:0] rs = '0;
  logic [NRD*DW-1:0] rv;
  logic [1:0]        we = '0;
  logic [2*AW-1:0]   rd = '0;
  logic [2*DW-1:0]   wdata = '0;
  logic [AW-1:0]     dbg_addr = '0;
  logic [DW-1:0]     dbg_data;
  logic              busy;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .clr(clr), .rs(rs), .rv(rv), .we(we), .rd(rd),
    .wdata(wdata), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rv0;
    logic [DW-1:0] rv1;
    logic [DW-1:0] dbg;
    logic          bsy;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;

  // Reference: register contents plus number of cycles still busy.
  logic [DW-1:0] model [NREG];
  int            busy_left = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (rst || busy_left > 0 || a == '0) return '0;
    v = model[a];
`ifdef REGFILE_MP_BYPASS_EN
    if (we[0] && rd[AW-1:0] == a)    v = wdata[DW-1:0];
    if (we[1] && rd[2*AW-1:AW] == a) v = wdata[2*DW-1:DW];
`endif
    return v;
  endfunction

  // One cycle: drive, predict, advance the clock, update the model.
  task automatic step(input logic r, input logic c, input logic [1:0] w,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                      input logic [AW-1:0] da);
    exp_t e;
    rst = r; clr = c; we = w;
    rd = {a1, a0}; wdata = {d1, d0}; rs = {s1, s0}; dbg_addr = da;
    e.rv0 = mread(s0);
    e.rv1 = mread(s1);
    e.dbg = mread(da);
    e.bsy = (busy_left > 0);
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      busy_left = NREG - 1;
      foreach (model[j]) model[j] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (w[0] && a0 != '0) model[a0] = d0;
      if (w[1] && a1 != '0) model[a1] = d1;
      if (c) begin
        busy_left = NREG - 1;
        foreach (model[j]) model[j] = '0;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] s0, input logic [AW-1:0] s1);
    step(1'b0, 1'b0, 2'b00, '0, '0, '0, '0, s0, s1, s1);
  endtask

  // Count cycles until busy drops, bounded.
  task automatic busy_len(input string name, input int want);
    int n = 0;
    while (busy && n < 2 * NREG) begin
      idle(AW'($urandom), AW'($urandom));
      n++;
    end
    chk(name, DW'(n), DW'(want));
  endtask

  // Monitor: compare whatever the driver predicted for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rv0",  rv[DW-1:0],    e.rv0);
        chk("rv1",  rv[2*DW-1:DW], e.rv1);
        chk("dbg",  dbg_data,      e.dbg);
        chk("busy", DW'(busy),     DW'(e.bsy));
      end
    end
  end

  initial begin
    foreach (model[j]) model[j] = '0;
    @(posedge clk); #1;

    // Reset: busy for exactly NREG-1 cycles, all reads zero.
    step(1'b1, 1'b0, 2'b11, 5'd3, 5'd4, 32'h1, 32'h2, 5'd3, 5'd4, 5'd0);
    busy_len("rst_busy_len", NREG - 1);
    for (int a = 0; a < NREG; a += 2) idle(AW'(a), AW'(a + 1));

    // Port 0 write then read; x0 write dropped.
    step(1'b0, 1'b0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, '0, 5'd5, 5'd0, 5'd5);
    idle(5'd5, 5'd0);
    step(1'b0, 1'b0, 2'b01, 5'd0, 5'd0, 32'h1, '0, 5'd0, 5'd5, 5'd0);
    idle(5'd0, 5'd5);

    // Collision: port 1 wins.
    step(1'b0, 1'b0, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 5'd7, 5'd7, 5'd7);
    idle(5'd7, 5'd5);

    // Same-cycle read of a written address (bypass or old value).
    step(1'b0, 1'b0, 2'b01, 5'd3, 5'd0, 32'h0BAD0BAD, '0, 5'd0, 5'd3, 5'd3);
    step(1'b0, 1'b0, 2'b01, 5'd3, 5'd0, 32'hA5A5A5A5, '0, 5'd0, 5'd3, 5'd3);
    idle(5'd3, 5'd3);

    // Clear with x31 populated; writes during clear dropped.
    step(1'b0, 1'b0, 2'b10, 5'd0, 5'd31, '0, 32'h1234, 5'd31, 5'd7, 5'd31);
    idle(5'd31, 5'd7);
    step(1'b0, 1'b1, 2'b00, '0, '0, '0, '0, 5'd31, 5'd7, 5'd31);
    step(1'b0, 1'b1, 2'b11, 5'd9, 5'd31, 32'h55, 32'h66, 5'd9, 5'd31, 5'd31);
    busy_len("clr_busy_len", NREG - 2);
    idle(5'd31, 5'd9);

    // Reset mid-clear at clr_ptr=10 restarts the walk.
    step(1'b0, 1'b1, 2'b00, '0, '0, '0, '0, 5'd1, 5'd2, 5'd3);
    for (int k = 0; k < 9; k++) idle(5'd1, 5'd2);
    step(1'b1, 1'b0, 2'b00, '0, '0, '0, '0, 5'd1, 5'd2, 5'd3);
    busy_len("rst_mid_clr_len", NREG - 1);

    // Random traffic, narrow address range to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] m;
      m = ($urandom_range(0, 1) == 0) ? AW'(7) : AW'(31);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
           2'($urandom),
           AW'($urandom) & m, AW'($urandom) & m,
           DW'($urandom), DW'($urandom),
           AW'($urandom) & m, AW'($urandom) & m, AW'($urandom) & m);
    end

    // Drain the scoreboard, bounded.
    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      errs++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
